// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered syncs, blanking and position outputs.
// Optional free-running frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic       frame_start,
  output logic [7:0] frame_cnt
`else
  output logic       frame_start
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_en_q, display_en_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
`endif

  // Outputs are decoded from the next position so they land on the same edge as it.
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    display_en_d  = display_en_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d       = '0;
        line_start_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end

      hsync_d      = !((hpos_d >= HS_BEG) && (hpos_d < HS_END));
      vsync_d      = !((vpos_d >= VS_BEG) && (vpos_d < VS_END));
      display_en_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
      x_d          = display_en_d ? hpos_d : 10'd0;
      y_d          = display_en_d ? vpos_d[8:0] : 9'd0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end
`endif

  // Reset parks the raster at (0,0), which is a visible, non-sync position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_en_q  <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_en_q  <= display_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_en  = display_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule
